// File: rtl/syn_seg_display.sv
// Seven-segment front end for the CPU syscall outputs: latches the displayed
// word, tracks a sticky halt, and scans 8 hex digits onto an active-low panel.
module syn_seg_display #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_SCANS = 64,
  parameter int LZ_BLANK    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] display,
  input  logic        display_en,
  input  logic        halt,
  input  logic        dbg_sel,
  input  logic [31:0] dbg_data,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic [31:0] shown,
  output logic        halted
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SCN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(BLINK_SCANS - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_shown;
  logic             r_halted;
  logic             r_blink;
  logic [SCN_W-1:0] r_scan_cnt;
  logic [7:0]       r_an_n;
  logic [7:0]       r_seg_n;

  logic             w_wrap;
  logic [31:0]      w_src;
  logic [4:0]       w_shift;
  logic [3:0]       w_nib;
  logic [6:0]       w_hex;
  logic             w_blank;
  logic             w_dp_n;

  assign w_wrap  = (r_div_cnt == DIV_LAST);
  assign w_src   = dbg_sel ? dbg_data : r_shown;
  assign w_shift = {r_idx, 2'b00};
  assign w_nib   = w_src[w_shift +: 4];
  assign w_dp_n  = !((r_idx == 3'd0) && r_halted && !r_blink);

  always_comb begin
    w_hex = 7'h7F;
    case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  // Digit 0 is never blanked so an all-zero word still shows "0".
  always_comb begin
    w_blank = 1'b0;
    if ((LZ_BLANK != 0) && (r_idx != 3'd0))
      w_blank = ((w_src >> w_shift) == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_idx      <= 3'd0;
      r_shown    <= 32'd0;
      r_halted   <= 1'b0;
      r_blink    <= 1'b0;
      r_scan_cnt <= '0;
      r_an_n     <= 8'hFF;
      r_seg_n    <= 8'hFF;
    end else begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 3'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (en && display_en && !r_halted)
        r_shown <= display;
      if (en && halt)
        r_halted <= 1'b1;

      // Blink phase only advances while halted, one step per full scan.
      if (!r_halted) begin
        r_blink    <= 1'b0;
        r_scan_cnt <= '0;
      end else if (w_wrap && (r_idx == 3'd7)) begin
        if (r_scan_cnt == SCN_LAST) begin
          r_scan_cnt <= '0;
          r_blink    <= ~r_blink;
        end else begin
          r_scan_cnt <= r_scan_cnt + 1'b1;
        end
      end

      r_an_n  <= ~(8'b1 << r_idx);
      r_seg_n <= {w_dp_n, (w_blank ? 7'h7F : w_hex)};
    end
  end

  assign seg_n  = r_seg_n;
  assign an_n   = r_an_n;
  assign shown  = r_shown;
  assign halted = r_halted;

endmodule

// File: tb/tb_syn_seg_display.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them against two DUTs (plain and zero-blanking).
module tb_syn_seg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] display;
  logic        display_en;
  logic        halt;
  logic        dbg_sel;
  logic [31:0] dbg_data;
  logic [7:0]  seg_n, an_n, lz_seg_n, lz_an_n;
  logic [31:0] shown, lz_shown;
  logic        halted, lz_halted;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int r0;

  typedef struct {
    int          cyc;
    int          dut;
    bit          c_out;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] sh;
    logic        h;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [7:0] an_tbl [8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] latch_tbl [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] a05_main [8] = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  logic [7:0] a05_lz [8]   = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  syn_seg_display #(.SCAN_DIV(4), .BLINK_SCANS(1), .LZ_BLANK(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .display(display), .display_en(display_en),
    .halt(halt), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .seg_n(seg_n), .an_n(an_n), .shown(shown), .halted(halted)
  );

  syn_seg_display #(.SCAN_DIV(4), .BLINK_SCANS(1), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst(rst), .en(en), .display(display), .display_en(display_en),
    .halt(halt), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .seg_n(lz_seg_n), .an_n(lz_an_n), .shown(lz_shown), .halted(lz_halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_out(input int t, input int d, input logic [7:0] an,
                          input logic [7:0] seg, input string nm);
    exp_t x;
    x.cyc = t; x.dut = d; x.c_out = 1'b1; x.an = an; x.seg = seg;
    x.sh = 32'd0; x.h = 1'b0; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic push_st(input int t, input logic [31:0] sh, input logic h,
                         input string nm);
    exp_t x;
    x.cyc = t; x.dut = 0; x.c_out = 1'b0; x.an = 8'h00; x.seg = 8'h00;
    x.sh = sh; x.h = h; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s missed slot: due cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (e.c_out) begin
        if (e.dut == 0) begin
          if (an_n !== e.an || seg_n !== e.seg) begin
            failures++;
            $display("FAIL %s cyc=%0d: got an_n=%h seg_n=%h, want an_n=%h seg_n=%h",
                     e.name, cyc, an_n, seg_n, e.an, e.seg);
          end
        end else begin
          if (lz_an_n !== e.an || lz_seg_n !== e.seg) begin
            failures++;
            $display("FAIL %s(lz) cyc=%0d: got an_n=%h seg_n=%h, want an_n=%h seg_n=%h",
                     e.name, cyc, lz_an_n, lz_seg_n, e.an, e.seg);
          end
        end
      end else begin
        if (shown !== e.sh || halted !== e.h || lz_shown !== e.sh || lz_halted !== e.h) begin
          failures++;
          $display("FAIL %s cyc=%0d: got shown=%h/%h halted=%b/%b, want shown=%h halted=%b",
                   e.name, cyc, shown, lz_shown, halted, lz_halted, e.sh, e.h);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; display = 32'd0; display_en = 1'b0;
    halt = 1'b0; dbg_sel = 1'b0; dbg_data = 32'd0;

    // Reset held for two edges, then idle scan of an all-zero word.
    @(negedge clk);
    push_out(cyc + 1, 0, 8'hFF, 8'hFF, "rst_out");
    push_out(cyc + 1, 1, 8'hFF, 8'hFF, "rst_out");
    push_st(cyc + 1, 32'd0, 1'b0, "rst_state");
    @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
    for (int k = 1; k <= 36; k++)
      push_out(r0 + k, 0, an_tbl[((k - 1) / 4) % 8], 8'hC0, "idle_scan");

    // Single-cycle latch of 1234ABCD, then one scan of its digits.
    wait_to(r0 + 64);
    en = 1'b1; display_en = 1'b1; display = 32'h1234ABCD;
    push_st(r0 + 65, 32'h1234ABCD, 1'b0, "latch");
    @(negedge clk);
    display_en = 1'b0;
    for (int d = 0; d < 8; d++)
      push_out(r0 + 67 + 4 * d, 0, an_tbl[d], latch_tbl[d], "latch_scan");

    // display_en without en is ignored.
    wait_to(r0 + 100);
    en = 1'b0; display_en = 1'b1; display = 32'hDEADBEEF;
    push_st(r0 + 101, 32'h1234ABCD, 1'b0, "gate_en");
    @(negedge clk);
    display_en = 1'b0; en = 1'b1;

    wait_to(r0 + 105);
    halt = 1'b1;
    push_st(r0 + 106, 32'h1234ABCD, 1'b1, "halt_set");
    @(negedge clk);
    halt = 1'b0;

    wait_to(r0 + 108);
    display_en = 1'b1; display = 32'hFFFFFFFF;
    push_st(r0 + 110, 32'h1234ABCD, 1'b1, "gate_halt");
    @(negedge clk);
    display_en = 1'b0;

    // Debug word 0 while halted: digit-0 dp alternates per scan.
    wait_to(r0 + 110);
    dbg_sel = 1'b1; dbg_data = 32'd0;
    for (int s = 4; s <= 7; s++) begin
      push_out(r0 + 3 + 32 * s, 0, 8'hFE, (s % 2 == 0) ? 8'hC0 : 8'h40, "blink_d0");
      push_out(r0 + 3 + 32 * s, 1, 8'hFE, (s % 2 == 0) ? 8'hC0 : 8'h40, "blink_d0");
      push_out(r0 + 15 + 32 * s, 0, 8'hF7, 8'hC0, "blink_d3");
      push_out(r0 + 15 + 32 * s, 1, 8'hF7, 8'hFF, "blank_zero_d3");
    end
    push_st(r0 + 240, 32'h1234ABCD, 1'b1, "halt_sticky");

    wait_to(r0 + 250);
    dbg_data = 32'h00000A05;
    for (int d = 0; d < 8; d++) begin
      push_out(r0 + 259 + 4 * d, 0, an_tbl[d], a05_main[d], "dbg_a05");
      push_out(r0 + 259 + 4 * d, 1, an_tbl[d], a05_lz[d], "blank_a05");
    end

    // Reset lands at idx=5, div_cnt=2 while halted.
    wait_to(r0 + 310);
    rst = 1'b1; dbg_sel = 1'b0;
    push_out(r0 + 311, 0, 8'hFF, 8'hFF, "midrst_out");
    push_out(r0 + 311, 1, 8'hFF, 8'hFF, "midrst_out");
    push_st(r0 + 311, 32'd0, 1'b0, "midrst_state");
    @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
    push_out(r0 + 1, 0, 8'hFE, 8'hC0, "restart_d0");
    push_out(r0 + 1, 1, 8'hFE, 8'hC0, "restart_d0");
    push_out(r0 + 5, 0, 8'hFD, 8'hC0, "restart_d1");
    push_out(r0 + 5, 1, 8'hFD, 8'hFF, "restart_d1");

    // Back-to-back latches: last one wins.
    wait_to(r0 + 6);
    en = 1'b1; display_en = 1'b1; display = 32'h11111111;
    push_st(r0 + 7, 32'h11111111, 1'b0, "b2b_first");
    @(negedge clk);
    display = 32'h22222222;
    push_st(r0 + 8, 32'h22222222, 1'b0, "b2b_second");
    @(negedge clk);
    display_en = 1'b0;

    // Halt and display in the same cycle still latches the word.
    wait_to(r0 + 10);
    display_en = 1'b1; halt = 1'b1; display = 32'hCAFE0001;
    push_st(r0 + 11, 32'hCAFE0001, 1'b1, "halt_and_latch");
    @(negedge clk);
    halt = 1'b0; display = 32'h55555555;
    push_st(r0 + 12, 32'hCAFE0001, 1'b1, "post_halt_gate");
    @(negedge clk);
    display_en = 1'b0;

    wait_to(r0 + 20);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syn_seg_display.md
Name: syn_seg_display

Overview:
- Downstream consumer of the CPU top's syscall outputs (display, display_en, halt) and its debug read ports.
- Latches the last displayed word and tracks the halted state.
- Time-multiplexes an 8-digit active-low seven-segment panel showing either the latched word or the debug word in hex.
- Marks the halted state on the digit-0 decimal point.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (>=2)
BLINK_SCANS, 64, full 8-digit scans per half-period of the halt blink (>=1)
LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 never blanked)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  CPU step/run enable (same signal fed to the CPU)
display  in  32  word from the CPU syscall unit
display_en  in  1  display word valid this cycle
halt  in  1  CPU halt request this cycle
dbg_sel  in  1  1 = show dbg_data, 0 = show latched word
dbg_data  in  32  debug word (regfile or data-memory debug read)
seg_n  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
an_n  out  8  digit enables, bit i = digit i (nibble i), active-low
shown  out  32  latched display word
halted  out  1  sticky halt flag

Behaviour:
- Reset (rst=1 at a clock edge) clears all state; it overrides every other input, including mid-scan.
  - Reset values: div_cnt=0, idx=0, shown=0, halted=0, blink=0, scan_cnt=0, an_n=8'hFF, seg_n=8'hFF.
- Latch:
  - If en && display_en && !halted, shown <= display at the next edge (1-cycle latency).
  - Otherwise shown holds its value.
- Halt:
  - If en && halt, halted <= 1. It is sticky until rst.
  - If display_en and halt are asserted in the same cycle and halted=0, the word is still latched.
- Divider: div_cnt counts 0..SCAN_DIV-1, runs freely (independent of en), and wraps to 0.
  - On wrap, idx <= idx+1 (3-bit, 7 wraps to 0).
- Blink: on the wrap where idx goes 7->0, scan_cnt increments.
  - When scan_cnt reaches BLINK_SCANS-1 and wraps to 0, blink toggles.
  - blink and scan_cnt count only while halted=1. They are held at 0 while halted=0.
- Source: src = dbg_sel ? dbg_data : shown. The switch is combinational and takes effect on the next output update.
- Outputs are registered every cycle from the current idx and src, so there is 1 cycle latency from an idx change to the an_n/seg_n change.
  - an_n <= ~(8'b1 << idx).
  - seg_n[6:0] <= hex decode of src[4*idx+3 : 4*idx].
- Hex table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - The full seg_n byte is these values with bit7 (dp) set, e.g. 0 -> C0.
- dp: seg_n[7] = 0 only when idx==0 && halted && !blink. It is 1 otherwise.
- Leading-zero blanking (LZ_BLANK=1): digit i>0 is blanked if src[31:4*i]==0.
  - A blanked digit drives seg_n[6:0]=7'h7F.
  - A blanked digit keeps its an_n enable, and its dp rule is unchanged.
  - With LZ_BLANK=0, no digit is ever blanked.
- No handshake back to the CPU. display_en pulses arriving every cycle are each latched (last one wins).

Test Plan:
- Reset/idle (SCAN_DIV=4): assert rst for 2 cycles, then release with no inputs.
  - During rst, an_n=FF and seg_n=FF.
  - After release, an_n steps FE, FD, FB, ..., 7F, each held 4 cycles, then FE again; every seg_n=C0.
- Latch: en=1, display_en=1, display=32'h1234ABCD for one cycle.
  - Next cycle shown=1234ABCD.
  - Scan seg_n per digit 0..7 = A1, C6, 83, 88, 99, B0, A4, F9.
- Gating:
  - display_en=1 with en=0 leaves shown unchanged.
  - After halted=1, display_en=1 with display=FFFFFFFF leaves shown=1234ABCD.
- Halt blink (BLINK_SCANS=1, SCAN_DIV=4): pulse en=1, halt=1, then display 0.
  - halted=1 sticky.
  - Digit-0 seg_n alternates 40/C0 on successive full scans (32 cycles each); other digits stay C0.
- Debug mux and blanking (LZ_BLANK=1): dbg_sel=1, dbg_data=32'h00000A05.
  - Digits 0..2 = 92, C0, 88.
  - Digits 3..7 = FF with an_n still enabled.
  - dbg_data=0 gives digit 0 = C0 and the rest FF.
- Mid-scan reset: rst at idx=5, div_cnt=2 while halted.
  - Next cycle an_n=FF, seg_n=FF, halted=0, shown=0.
  - Scan restarts at digit 0 after release.
